// File: rtl/fb_write_queue.sv
// rtl/fb_write_queue.sv - pixel write queue feeding a framebuffer memory port
//
// Accepts (x, y, color) pixels, converts each one to a byte address at
// acceptance time, queues {address, color} in a FIFO and plays the entries
// out one at a time on a req/ack memory write port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_fb_base_addr    framebuffer base byte address, sampled per pixel
//   i_pixel_valid/o_pixel_ready, i_pixel_x/y, i_pixel_color   pixel input
//   o_mem_req/i_mem_ack, o_mem_addr, o_mem_wdata              memory write
//   o_fifo_level      queued entries (output register not included)
//   o_busy            queue non-empty or request outstanding
//   o_drop_count      clipped-pixel count
//
// Build option: define FB_WRITE_QUEUE_CLIP_EN to drop off-screen pixels and
// count them; otherwise every pixel is queued and o_drop_count is 0.

module fb_write_queue #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int COLOR_WIDTH   = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int COORD_WIDTH   = 10,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [ADDR_WIDTH-1:0]              i_fb_base_addr,
   input  logic                               i_pixel_valid,
   output logic                               o_pixel_ready,
   input  logic [COORD_WIDTH-1:0]             i_pixel_x,
   input  logic [COORD_WIDTH-1:0]             i_pixel_y,
   input  logic [COLOR_WIDTH-1:0]             i_pixel_color,
   output logic                               o_mem_req,
   input  logic                               i_mem_ack,
   output logic [ADDR_WIDTH-1:0]              o_mem_addr,
   output logic [COLOR_WIDTH-1:0]             o_mem_wdata,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level,
   output logic                               o_busy,
   output logic [15:0]                        o_drop_count
);

   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int BYTE_SHIFT = $clog2(COLOR_WIDTH / 8);
   localparam int ENTRY_W    = ADDR_WIDTH + COLOR_WIDTH;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t                  state_q;
   logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    ready_en_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [COLOR_WIDTH-1:0]  wdata_q;

   logic                    fifo_full, fifo_empty;
   logic                    accept, clipped, push, pop;
   logic [ADDR_WIDTH-1:0]   pix_off, entry_addr;
   logic [ADDR_WIDTH-1:0]   head_addr;
   logic [COLOR_WIDTH-1:0]  head_data;

   assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);

   // ready_en_q holds ready low through reset and up to the first edge after it
   assign o_pixel_ready = ready_en_q && !fifo_full;
   assign accept        = i_pixel_valid && o_pixel_ready;

   // Linear pixel index scaled to bytes; wraps modulo 2^ADDR_WIDTH
   assign pix_off    = ADDR_WIDTH'(i_pixel_y) * ADDR_WIDTH'(SCREEN_WIDTH)
                     + ADDR_WIDTH'(i_pixel_x);
   assign entry_addr = i_fb_base_addr + (pix_off << BYTE_SHIFT);

`ifdef FB_WRITE_QUEUE_CLIP_EN
   localparam logic [31:0] SW_U = SCREEN_WIDTH;
   localparam logic [31:0] SH_U = SCREEN_HEIGHT;
   logic [15:0] drop_q;

   assign clipped = (32'(i_pixel_x) >= SW_U) || (32'(i_pixel_y) >= SH_U);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else if (accept && clipped && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end
   assign o_drop_count = drop_q;
`else
   assign clipped      = 1'b0;
   assign o_drop_count = '0;
`endif

   assign push = accept && !clipped;
   // A pop happens whenever the output register is free to take the head:
   // in IDLE, or in REQ on the ack that retires the current request.
   assign pop  = !fifo_empty && ((state_q == S_IDLE) || i_mem_ack);

   assign {head_addr, head_data} = fifo_mem[rd_ptr_q];
   assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

   // Storage is not reset; validity is tracked entirely by the pointers/level
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {entry_addr, i_pixel_color};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         level_q    <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  addr_q  <= head_addr;
                  wdata_q <= head_data;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_mem_ack) begin
                  if (!fifo_empty) begin
                     addr_q  <= head_addr;
                     wdata_q <= head_data;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_mem_req    = (state_q == S_REQ);
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;
   assign o_fifo_level = level_q;
   assign o_busy       = !fifo_empty || (state_q == S_REQ);

endmodule

// File: tb/tb_fb_write_queue.sv
// tb/tb_fb_write_queue.sv - scoreboard bench for fb_write_queue

module tb_fb_write_queue;

   localparam int SW    = 640;
   localparam int SH    = 480;
   localparam int CW    = 32;
   localparam int AW    = 32;
   localparam int CRD   = 10;
   localparam int DEPTH = 8;
   localparam int LVLW  = $clog2(DEPTH + 1);

`ifdef FB_WRITE_QUEUE_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   fb_base = '0;
   logic            pix_valid = 1'b0;
   logic            pix_ready;
   logic [CRD-1:0]  pix_x = '0;
   logic [CRD-1:0]  pix_y = '0;
   logic [CW-1:0]   pix_color = '0;
   logic            mem_req;
   logic            mem_ack = 1'b0;
   logic [AW-1:0]   mem_addr;
   logic [CW-1:0]   mem_wdata;
   logic [LVLW-1:0] fifo_level;
   logic            busy;
   logic [15:0]     drop_count;

   always #5 clk = ~clk;

   fb_write_queue #(
      .SCREEN_WIDTH (SW),
      .SCREEN_HEIGHT(SH),
      .COLOR_WIDTH  (CW),
      .ADDR_WIDTH   (AW),
      .COORD_WIDTH  (CRD),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_fb_base_addr(fb_base),
      .i_pixel_valid (pix_valid),
      .o_pixel_ready (pix_ready),
      .i_pixel_x     (pix_x),
      .i_pixel_y     (pix_y),
      .i_pixel_color (pix_color),
      .o_mem_req     (mem_req),
      .i_mem_ack     (mem_ack),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_fifo_level  (fifo_level),
      .o_busy        (busy),
      .o_drop_count  (drop_count)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [CW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   model_drops = 0;
   int   req_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference address: linear pixel index times bytes per pixel, added to
   // the base and truncated to the address width.
   function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int x, input int y);
      longint off;
      off = (longint'(y) * SW + longint'(x)) * (CW / 8);
      return base + off[AW-1:0];
   endfunction

   // Acceptance model pushes expectations; monitor pops on each acked request
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && pix_valid && pix_ready) begin
            if (CLIP && ((int'(pix_x) >= SW) || (int'(pix_y) >= SH))) begin
               if (model_drops < 16'hFFFF) model_drops++;
            end else begin
               e.addr = model_addr(fb_base, int'(pix_x), int'(pix_y));
               e.data = pix_color;
               sb.push_back(e);
            end
         end
         if (mem_req) begin
            req_seen++;
            if (mem_ack) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_underflow: got request addr 0x%0h with nothing expected", mem_addr);
               end else begin
                  e = sb.pop_front();
                  check("mem_addr", 64'(mem_addr), 64'(e.addr));
                  check("mem_wdata", 64'(mem_wdata), 64'(e.data));
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [AW-1:0] base, input int x, input int y, input logic [CW-1:0] c);
      fb_base   = base;
      pix_x     = CRD'(x);
      pix_y     = CRD'(y);
      pix_color = c;
      pix_valid = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      pix_valid = 1'b0;
      mem_ack   = 1'b1;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_busy", 64'(busy), 64'(0));
      check("drain_sb_empty", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      int acc, start, run, longest, total;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(pix_ready), 0);
      check("rst_req", 64'(mem_req), 0);
      check("rst_addr", 64'(mem_addr), 0);
      check("rst_wdata", 64'(mem_wdata), 0);
      check("rst_level", 64'(fifo_level), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_drop", 64'(drop_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 64'(pix_ready), 0);
      @(posedge clk); #1;
      check("ready_after_release", 64'(pix_ready), 1);

      // Single pixel latency and address
      mem_ack = 1'b1;
      send(32'h1000_0000, 3, 2, 32'hAABB_CCDD);
      check("lat_req_edgeN", 64'(mem_req), 0);
      @(posedge clk); #1;
      check("lat_req_edgeN1", 64'(mem_req), 1);
      check("lat_addr", 64'(mem_addr), 64'h1000_140C);
      check("lat_wdata", 64'(mem_wdata), 64'hAABB_CCDD);
      @(posedge clk); #1;
      check("lat_req_one_cycle", 64'(mem_req), 0);

      // Capacity with the memory stalled
      mem_ack   = 1'b0;
      fb_base   = 32'h0400_0000;
      pix_y     = CRD'(1);
      acc       = 0;
      pix_valid = 1'b1;
      repeat (14) begin
         pix_x = CRD'(acc);
         pix_color = $urandom;
         @(negedge clk);
         if (pix_ready) acc++;
         @(posedge clk); #1;
      end
      check("cap_accepted", 64'(acc), 9);
      check("cap_ready_low", 64'(pix_ready), 0);
      check("cap_level", 64'(fifo_level), 8);
      check("cap_req", 64'(mem_req), 1);
      check("cap_busy", 64'(busy), 1);
      pix_x   = CRD'(acc);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("cap_level_after_pop", 64'(fifo_level), 7);
      repeat (6) begin
         pix_x = CRD'(acc);
         pix_color = $urandom;
         @(negedge clk);
         if (pix_ready) acc++;
         @(posedge clk); #1;
      end
      check("cap_one_more", 64'(acc), 10);
      check("cap_level_refill", 64'(fifo_level), 8);
      drain();

      // Back-to-back burst
      mem_ack = 1'b1;
      fb_base = 32'h2000_0000;
      run = 0; longest = 0; total = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 4) begin
            pix_x = CRD'(i); pix_y = '0; pix_color = $urandom; pix_valid = 1'b1;
         end else begin
            pix_valid = 1'b0;
         end
         @(posedge clk); #1;
         if (mem_req) begin
            run++; total++;
            if (run > longest) longest = run;
         end else begin
            run = 0;
         end
      end
      check("burst_longest_run", 64'(longest), 4);
      check("burst_total", 64'(total), 4);

      // Off-screen coordinates
      start = req_seen;
      send(32'h0, 640, 0, 32'h1111_2222);
      send(32'h0, 0, 480, 32'h3333_4444);
      repeat (6) @(posedge clk);
      #1;
      check("clip_req_cycles", 64'(req_seen - start), CLIP ? 64'd0 : 64'd2);
      check("clip_drop_count", 64'(drop_count), CLIP ? 64'd2 : 64'd0);

      // Address wrap-around
      mem_ack = 1'b0;
      send(32'hFFFF_FFF0, 8, 0, 32'h5A5A_5A5A);
      @(posedge clk); #1;
      check("wrap_req", 64'(mem_req), 1);
      check("wrap_addr", 64'(mem_addr), 64'h0000_0010);
      drain();

      // Reset in the middle of a request with three entries queued
      mem_ack = 1'b0;
      fb_base = 32'h3000_0000;
      pix_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pix_x = CRD'(i); pix_y = CRD'(5); pix_color = $urandom;
         @(posedge clk); #1;
      end
      pix_valid = 1'b0;
      check("mid_req", 64'(mem_req), 1);
      check("mid_level", 64'(fifo_level), 3);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      model_drops = 0;
      check("arst_req", 64'(mem_req), 0);
      check("arst_addr", 64'(mem_addr), 0);
      check("arst_wdata", 64'(mem_wdata), 0);
      check("arst_level", 64'(fifo_level), 0);
      check("arst_busy", 64'(busy), 0);
      check("arst_ready", 64'(pix_ready), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      start = req_seen;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_req", 64'(req_seen - start), 0);
      check("post_rst_level", 64'(fifo_level), 0);

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         pix_valid = ($urandom_range(0, 99) < 60);
         pix_x     = CRD'($urandom_range(0, 700));
         pix_y     = CRD'($urandom_range(0, 520));
         pix_color = $urandom;
         fb_base   = $urandom;
         mem_ack   = ($urandom_range(0, 99) < 50);
         @(posedge clk); #1;
      end
      drain();
      check("final_drop_count", 64'(drop_count), 64'(model_drops));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_write_queue.md
FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

Interface
REQ-001 The block SHALL have parameter SCREEN_WIDTH, default 640, pixels per row (row stride).
REQ-002 The block SHALL have parameter SCREEN_HEIGHT, default 480, rows per frame.
REQ-003 The block SHALL have parameter COLOR_WIDTH, default 32, bits per pixel, legal values 8/16/32.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-005 The block SHALL have parameter COORD_WIDTH, default 10, width of the x/y coordinates.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 8, write-queue entries, power of two and at least 2.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port i_fb_base_addr, input, ADDR_WIDTH bits: framebuffer base byte address.
REQ-010 The block SHALL have ports i_pixel_valid, input, 1 bit, and o_pixel_ready, output, 1 bit: the pixel-side handshake.
REQ-011 The block SHALL have ports i_pixel_x and i_pixel_y, input, COORD_WIDTH bits each: pixel coordinates.
REQ-012 The block SHALL have port i_pixel_color, input, COLOR_WIDTH bits: pixel data.
REQ-013 The block SHALL have ports o_mem_req, output, 1 bit, and i_mem_ack, input, 1 bit: the memory-side handshake.
REQ-014 The block SHALL have ports o_mem_addr, output, ADDR_WIDTH bits, and o_mem_wdata, output, COLOR_WIDTH bits: the memory write address and data.
REQ-015 The block SHALL have port o_fifo_level, output, $clog2(FIFO_DEPTH+1) bits: queue occupancy.
REQ-016 The block SHALL have port o_busy, output, 1 bit: high when the queue is non-empty or a request is outstanding.
REQ-017 The block SHALL have port o_drop_count, output, 16 bits: count of clipped pixels.

Function
REQ-018 A pixel SHALL be accepted on a rising edge where i_pixel_valid && o_pixel_ready; o_pixel_ready SHALL equal !fifo_full, and a same-cycle pop SHALL NOT make room for a push.
REQ-019 The address SHALL be computed at acceptance as i_fb_base_addr + ((y*SCREEN_WIDTH + x) << log2(COLOR_WIDTH/8)), truncated modulo 2^ADDR_WIDTH; i_fb_base_addr is sampled per pixel, not per frame.
REQ-020 The FIFO SHALL store {address, color} in acceptance order; ordering SHALL be strictly preserved.
REQ-021 The memory-side FSM SHALL have two states, IDLE and REQ.
REQ-022 In IDLE with the FIFO non-empty, the FSM SHALL load the FIFO head into the output registers, pop the FIFO, and enter REQ.
REQ-023 o_mem_req SHALL be high exactly while in REQ; o_mem_addr and o_mem_wdata SHALL be registered and held stable until i_mem_ack.
REQ-024 In REQ, on i_mem_ack with the FIFO non-empty, the FSM SHALL load the next entry in the same edge and stay in REQ, giving back-to-back requests; with the FIFO empty it SHALL return to IDLE.
REQ-025 i_mem_ack SHALL be ignored while in IDLE.
REQ-026 Latency SHALL be one cycle: a pixel accepted at edge N into an empty, idle queue SHALL raise o_mem_req after edge N+1.
REQ-027 Sustained throughput SHALL be one pixel per cycle when i_mem_ack is held high.
REQ-028 Capacity SHALL be FIFO_DEPTH queued entries plus 1 entry in the output register.
REQ-029 o_fifo_level SHALL count queued entries only, excluding the output register; an accept and a pop in the same cycle SHALL leave the level unchanged.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear the FIFO, the pointers, the FSM (to IDLE) and o_drop_count.
REQ-031 While rst_n is low, o_mem_req, o_mem_addr, o_mem_wdata, o_fifo_level and o_busy SHALL be 0 and o_pixel_ready SHALL be 0.
REQ-032 o_pixel_ready SHALL rise on the first clock edge after rst_n is released.
REQ-033 Reset asserted mid-request SHALL discard the outstanding request and all queued pixels, with no replay after reset is released.

Configuration
REQ-034 With macro FB_WRITE_QUEUE_CLIP_EN defined, a pixel with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT SHALL complete the handshake but SHALL NOT be enqueued, and o_drop_count SHALL increment, saturating at 0xFFFF.
REQ-035 With FB_WRITE_QUEUE_CLIP_EN undefined, every pixel SHALL be enqueued unchecked and o_drop_count SHALL be tied to 0.

Verification
REQ-036 Base 0x1000_0000, pixel (3,2) color 0xAABBCCDD, i_mem_ack high -> o_mem_addr 0x1000_140C, o_mem_wdata 0xAABBCCDD, o_mem_req high 1 cycle, starting 1 cycle after acceptance.
REQ-037 i_mem_ack low, 10 pixels offered back-to-back, FIFO_DEPTH 8 -> 9 accepted, o_pixel_ready low, o_fifo_level 8; pulsing i_mem_ack once -> 1 more accepted.
REQ-038 4 pixels (0..3,0), i_mem_ack held high -> o_mem_req high 4 consecutive cycles with addresses base+0x0, +0x4, +0x8, +0xC in order.
REQ-039 Pixels (640,0) and (0,480), base 0: with CLIP_EN -> no requests, o_drop_count 2; without CLIP_EN -> requests to 0xA00 and 0x12C000.
REQ-040 rst_n low while o_mem_req is high with 3 entries queued -> all outputs 0 asynchronously; after release, no requests appear and o_fifo_level is 0.
REQ-041 Base 0xFFFF_FFF0, pixel (8,0) -> o_mem_addr 0x0000_0010 (wrap-around).
